// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: sequencer for an external asynchronous SRAM behind a req/ack host port.
// Strobes CE/OE/WE with programmable access width, controls DQ pad direction, and
// registers every SRAM-side output.
// Optional feature macro: SRAM_BANK_EN adds a bank register that drives the upper address pins.
module sram_async_ctrl #(
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned CPU_AW   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       we,
  input  logic [CPU_AW-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       ready,
  output logic                       ack,
  output logic [DATA_W-1:0]          rdata,
  input  logic                       bank_we,
  input  logic [ADDR_W-CPU_AW-1:0]   bank_wdata,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic                       sram_dq_oe,
  output logic [DATA_W-1:0]          sram_dq_out,
  input  logic [DATA_W-1:0]          sram_dq_in
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_we_q, op_we_d;
  logic              accept;
  logic [ADDR_W-1:0] upper_addr;

  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;

`ifdef SRAM_BANK_EN
  logic [ADDR_W-CPU_AW-1:0] bank_q, bank_d;

  // Bank register update; a request accepted on the same edge still sees the old value.
  always_comb begin
    bank_d = bank_q;
    if (bank_we) bank_d = bank_wdata;
  end

  // Bank register.
  always_ff @(posedge clk) begin
    if (reset) bank_q <= '0;
    else       bank_q <= bank_d;
  end

  // Bank lands above the host address bits; vanishes when CPU_AW == ADDR_W.
  assign upper_addr = ADDR_W'(bank_q) << CPU_AW;
`else
  logic unused_bank;
  assign unused_bank = ^{bank_we, bank_wdata};
  assign upper_addr  = '0;
`endif

  assign accept = (state_q == ST_IDLE) && req && ready_q;

  // State register with the access counter and latched direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_we_q <= op_we_d;
    end
  end

  // Next-state logic: IDLE -> SETUP -> ACCESS(WAIT_CYC) -> IDLE (read) or HOLD -> IDLE (write).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_we_d = op_we_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          op_we_d = we;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_W'(WAIT_CYC - 1);
      end
      ST_ACCESS: begin
        if (cnt_q == '0) state_d = op_we_q ? ST_HOLD : ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode for the state being entered, so pins are registered with the state.
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    case (state_d)
      ST_SETUP: begin
        ce_n_d      = 1'b0;
        sram_addr_d = upper_addr | ADDR_W'(addr);
        if (op_we_d) begin
          dq_oe_d  = 1'b1;
          dq_out_d = wdata;
        end else begin
          oe_n_d   = 1'b0;
        end
      end
      ST_ACCESS: begin
        ce_n_d = 1'b0;
        if (op_we_q) begin
          we_n_d  = 1'b0;
          dq_oe_d = 1'b1;
        end else begin
          oe_n_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      ST_IDLE: begin
        if (state_q == ST_ACCESS && !op_we_q) begin
          ack_d   = 1'b1;
          rdata_d = sram_dq_in;
        end else if (state_q == ST_HOLD) begin
          ack_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b1;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign ready       = ready_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_dq_out = dq_out_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed bench for sram_async_ctrl with WAIT_CYC=2 and a behavioural SRAM model.
module tb_sram_async_ctrl;

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned CPU_AW   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WAIT_CYC = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req;
  logic                     we;
  logic [CPU_AW-1:0]        addr;
  logic [DATA_W-1:0]        wdata;
  logic                     ready;
  logic                     ack;
  logic [DATA_W-1:0]        rdata;
  logic                     bank_we;
  logic [ADDR_W-CPU_AW-1:0] bank_wdata;
  logic [ADDR_W-1:0]        sram_addr;
  logic                     sram_ce_n;
  logic                     sram_oe_n;
  logic                     sram_we_n;
  logic                     sram_dq_oe;
  logic [DATA_W-1:0]        sram_dq_out;
  logic [DATA_W-1:0]        sram_dq_in = 8'h00;

  int nvec = 0;
  int nerr = 0;

  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  sram_async_ctrl #(
    .ADDR_W  (ADDR_W),
    .CPU_AW  (CPU_AW),
    .DATA_W  (DATA_W),
    .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .ack        (ack),
    .rdata      (rdata),
    .bank_we    (bank_we),
    .bank_wdata (bank_wdata),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: captures writes while WE is low, drives DQ while OE is low.
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_out;
    if (!sram_ce_n && !sram_oe_n)
      sram_dq_in = mem.exists(sram_addr) ? mem[sram_addr] : 8'hEE;
    else
      sram_dq_in = 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) begin
      nvec++; nerr++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
    end
  endtask

  // pins = {ready, ack, ce_n, oe_n, we_n, dq_oe}
  task automatic test_reset();
    logic [5:0] pins;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      pins = {ready, ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
      nvec++;
      if (pins !== 6'b10_1110) begin
        nerr++;
        $display("FAIL reset_pins cycle %0d: got %b required %b", i, pins, 6'b101110);
      end
      nvec++;
      if (sram_addr !== 19'h0 || rdata !== 8'h00 || sram_dq_out !== 8'h00) begin
        nerr++;
        $display("FAIL reset_regs cycle %0d: addr=%h rdata=%h dq_out=%h required 0/0/0",
                 i, sram_addr, rdata, sram_dq_out);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_write(input string name, input logic [15:0] a, input logic [7:0] d,
                            input logic [18:0] exp_addr);
    logic [5:0] exp_p [5];
    logic [5:0] pins;
    int we_low = 0;
    exp_p = '{6'b00_0111, 6'b00_0101, 6'b00_0101, 6'b00_0111, 6'b11_1110};
    wait_ready();
    we = 1'b1; addr = a; wdata = d; req = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pins = {ready, ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
      if (sram_we_n === 1'b0) we_low++;
      nvec++;
      if (pins !== exp_p[c]) begin
        nerr++;
        $display("FAIL %s_pins cycle %0d: got %b required %b", name, c, pins, exp_p[c]);
      end
      if (c < 4) begin
        nvec++;
        if (sram_dq_out !== d || sram_addr !== exp_addr) begin
          nerr++;
          $display("FAIL %s_bus cycle %0d: dq_out=%h addr=%h required %h/%h",
                   name, c, sram_dq_out, sram_addr, d, exp_addr);
        end
        tick();
      end
    end
    nvec++;
    if (we_low != 2) begin
      nerr++;
      $display("FAIL %s_we_width: we_n low %0d cycles, required 2", name, we_low);
    end
    nvec++;
    if (!mem.exists(exp_addr) || mem[exp_addr] !== d) begin
      nerr++;
      $display("FAIL %s_mem: model byte at %h missing or wrong, required %h", name, exp_addr, d);
    end
  endtask

  task automatic test_read(input string name, input logic [15:0] a, input logic [7:0] exp_d,
                           input logic [18:0] exp_addr);
    logic [5:0] exp_p [4];
    logic [5:0] pins;
    int oe_low = 0;
    exp_p = '{6'b00_0010, 6'b00_0010, 6'b00_0010, 6'b11_1110};
    wait_ready();
    we = 1'b0; addr = a; req = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pins = {ready, ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
      if (sram_oe_n === 1'b0) oe_low++;
      nvec++;
      if (pins !== exp_p[c]) begin
        nerr++;
        $display("FAIL %s_pins cycle %0d: got %b required %b", name, c, pins, exp_p[c]);
      end
      if (c == 0) begin
        nvec++;
        if (sram_addr !== exp_addr) begin
          nerr++;
          $display("FAIL %s_addr: got %h required %h", name, sram_addr, exp_addr);
        end
      end
      if (c < 3) tick();
    end
    nvec++;
    if (rdata !== exp_d) begin
      nerr++;
      $display("FAIL %s_rdata: got %h required %h", name, rdata, exp_d);
    end
    nvec++;
    if (oe_low != 3) begin
      nerr++;
      $display("FAIL %s_oe_width: oe_n low %0d cycles, required 3", name, oe_low);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pins;
    wait_ready();
    we = 1'b1; addr = 16'h0001; wdata = 8'h11; req = 1'b1;
    tick();                           // write accepted
    we = 1'b0;                        // req stays high with the read request
    tick(); tick(); tick();           // HOLD now; held req must not disturb the write
    pins = {ready, ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
    nvec++;
    if (pins !== 6'b00_0111) begin
      nerr++;
      $display("FAIL b2b_hold: got %b required %b", pins, 6'b000111);
    end
    tick();                           // write ack cycle
    pins = {ready, ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
    nvec++;
    if (pins !== 6'b11_1110) begin
      nerr++;
      $display("FAIL b2b_wr_ack: got %b required %b", pins, 6'b111110);
    end
    tick();                           // read accepted in the ack cycle
    req = 1'b0;
    pins = {ready, ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
    nvec++;
    if (pins !== 6'b00_0010 || sram_addr !== 19'h00001) begin
      nerr++;
      $display("FAIL b2b_rd_setup: pins=%b addr=%h required %b/%h", pins, sram_addr,
               6'b000010, 19'h00001);
    end
    tick(); tick(); tick();
    nvec++;
    if (ack !== 1'b1 || rdata !== 8'h11) begin
      nerr++;
      $display("FAIL b2b_rd_ack: ack=%b rdata=%h required 1/11", ack, rdata);
    end
  endtask

  task automatic test_bank();
    logic [18:0] exp_addr;
    wait_ready();
    bank_we = 1'b1; bank_wdata = 3'b101;
    tick();
    bank_we = 1'b0; bank_wdata = 3'b000;
`ifdef SRAM_BANK_EN
    exp_addr = 19'h5FFFF;
`else
    exp_addr = 19'h0FFFF;
`endif
    test_read("bank_rd", 16'hFFFF, 8'hEE, exp_addr);
  endtask

  task automatic test_reset_mid_write();
    logic [5:0] pins;
    logic       saw_ack = 1'b0;
    wait_ready();
    we = 1'b1; addr = 16'h0042; wdata = 8'h3C; req = 1'b1;
    tick();
    req = 1'b0;
    tick();                           // ACCESS with we_n low
    nvec++;
    if (sram_we_n !== 1'b0) begin
      nerr++;
      $display("FAIL abort_pre: we_n=%b required 0", sram_we_n);
    end
    reset = 1'b1;
    tick();
    pins = {ready, ack, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
    nvec++;
    if (pins !== 6'b10_1110 || sram_addr !== 19'h0) begin
      nerr++;
      $display("FAIL abort_reset: pins=%b addr=%h required %b/0", pins, sram_addr, 6'b101110);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack === 1'b1 || sram_we_n !== 1'b1) saw_ack = 1'b1;
    end
    nvec++;
    if (saw_ack) begin
      nerr++;
      $display("FAIL abort_no_ack: ack or we_n activity after aborted write, required none");
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    bank_we = 1'b0; bank_wdata = '0;
    test_reset();
    test_write("wr1234", 16'h1234, 8'hA5, 19'h01234);
    test_read("rd1234", 16'h1234, 8'hA5, 19'h01234);
    test_back_to_back();
    test_bank();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
